// File: rtl/icm_buffer_sram_arbiter_pkg.sv
// Shared definitions for the ICM cache SRAM arbiter: channel indices, FSM
// state codes and small channel-index helpers.
package icm_buffer_sram_arbiter_pkg;

  localparam int ARB_CH_GET = 0;
  localparam int ARB_CH_SET = 1;
  localparam int ARB_CH_DEL = 2;
  localparam int ARB_CH_NUM = 3;

  typedef logic [1:0] arb_ch_t;

  localparam logic [0:0] IDLE_s  = 1'b0;
  localparam logic [0:0] GRANT_s = 1'b1;

  // Next channel in round-robin order; the unused code 3 folds back to channel 0.
  function automatic arb_ch_t arb_next_ptr(input arb_ch_t ch);
    return (ch >= 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

  function automatic arb_ch_t arb_oh2idx(input logic [2:0] oh);
    case (oh)
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/icm_buffer_sram_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: one-hot of the first requester at
// or after rr_ptr_i, wrapping modulo 3.
module icm_rr_pick3
  import icm_buffer_sram_arbiter_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] rr_ptr_i,
  output logic [2:0] gnt_o
);

  arb_ch_t c;
  logic    found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    c     = (rr_ptr_i > 2'd2) ? 2'd0 : rr_ptr_i;
    for (int k = 0; k < ARB_CH_NUM; k++) begin
      if (!found && req_i[c]) begin
        gnt_o[c] = 1'b1;
        found    = 1'b1;
      end
      c = arb_next_ptr(c);
    end
  end

endmodule

// File: rtl/icm_buffer_sram_arbiter.sv
// Round-robin owner arbiter sharing one ICM cache SRAM set (way_0, way_1, LRU)
// between Get/Set/Invalidate threads. Optional perf counters: ICM_SRAM_ARB_PERF_EN.
module icm_buffer_sram_arbiter
  import icm_buffer_sram_arbiter_pkg::*;
#(
  parameter int CACHE_ENTRY_WIDTH = 256,
  parameter int CACHE_TAG_WIDTH   = 10,
  parameter int CACHE_SET_NUM_LOG = 10,
  parameter int SRAM_WIDTH        = CACHE_ENTRY_WIDTH + CACHE_TAG_WIDTH + 1,
  parameter int MAX_HOLD          = 16,
  parameter int MAX_HOLD_LOG      = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [2:0]                      req,
  output logic [2:0]                      gnt,
  input  logic [2:0]                      ch_way0_wen,
  input  logic [2:0]                      ch_way1_wen,
  input  logic [2:0]                      ch_lru_wen,
  input  logic [3*CACHE_SET_NUM_LOG-1:0]  ch_way0_addr,
  input  logic [3*CACHE_SET_NUM_LOG-1:0]  ch_way1_addr,
  input  logic [3*CACHE_SET_NUM_LOG-1:0]  ch_lru_addr,
  input  logic [3*SRAM_WIDTH-1:0]         ch_way0_din,
  input  logic [3*SRAM_WIDTH-1:0]         ch_way1_din,
  input  logic [2:0]                      ch_lru_din,
  output logic                            way_0_wen,
  output logic                            way_1_wen,
  output logic                            lru_wen,
  output logic [CACHE_SET_NUM_LOG-1:0]    way_0_addr,
  output logic [CACHE_SET_NUM_LOG-1:0]    way_1_addr,
  output logic [CACHE_SET_NUM_LOG-1:0]    lru_addr,
  output logic [SRAM_WIDTH-1:0]           way_0_din,
  output logic [SRAM_WIDTH-1:0]           way_1_din,
  output logic                            lru_din,
  input  logic [SRAM_WIDTH-1:0]           way_0_dout,
  input  logic [SRAM_WIDTH-1:0]           way_1_dout,
  input  logic                            lru_dout,
  output logic [SRAM_WIDTH-1:0]           ch_way0_dout,
  output logic [SRAM_WIDTH-1:0]           ch_way1_dout,
  output logic                            ch_lru_dout,
  output logic                            hold_err
`ifdef ICM_SRAM_ARB_PERF_EN
  ,
  output logic [3*32-1:0]                 perf_grant_cnt,
  output logic [3*32-1:0]                 perf_wait_cnt
`endif
);

  localparam int AW = CACHE_SET_NUM_LOG;
  localparam int SW = SRAM_WIDTH;
  localparam logic [MAX_HOLD_LOG-1:0] HOLD_MAX = MAX_HOLD_LOG'(MAX_HOLD);

  logic [0:0]              state_q, state_d;
  logic [2:0]              gnt_q, gnt_d;
  arb_ch_t                 rr_ptr_q, rr_ptr_d;
  logic [MAX_HOLD_LOG-1:0] hold_cnt_q, hold_cnt_d;
  logic                    hold_err_q, hold_err_d;
  logic [2:0]              pick;
  arb_ch_t                 owner;
  logic                    owner_req, others_wait;

  icm_rr_pick3 u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (pick)
  );

  assign owner       = arb_oh2idx(gnt_q);
  assign owner_req   = |(req & gnt_q);
  assign others_wait = |(req & ~gnt_q);

  // Ownership only changes through IDLE_s, so a new owner never sees the
  // previous owner's bundle in the same cycle.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    hold_err_d = hold_err_q;
    case (state_q)
      IDLE_s: begin
        hold_cnt_d = '0;
        if (|req) begin
          gnt_d   = pick;
          state_d = GRANT_s;
        end
      end
      GRANT_s: begin
        if (hold_cnt_q == HOLD_MAX && others_wait) hold_err_d = 1'b1;
        if (owner_req) begin
          if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + MAX_HOLD_LOG'(1);
        end else begin
          gnt_d    = '0;
          state_d  = IDLE_s;
          rr_ptr_d = arb_next_ptr(owner);
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE_s;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE_s;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      hold_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      hold_err_q <= hold_err_d;
    end
  end

  assign gnt      = gnt_q;
  assign hold_err = hold_err_q;

  // Mux keys off registered gnt_q, so an async reset silences writes immediately.
  always_comb begin
    way_0_wen  = 1'b0;
    way_1_wen  = 1'b0;
    lru_wen    = 1'b0;
    way_0_addr = '0;
    way_1_addr = '0;
    lru_addr   = '0;
    way_0_din  = '0;
    way_1_din  = '0;
    lru_din    = 1'b0;
    for (int i = 0; i < ARB_CH_NUM; i++) begin
      if (state_q == GRANT_s && gnt_q[i]) begin
        way_0_wen  = ch_way0_wen[i];
        way_1_wen  = ch_way1_wen[i];
        lru_wen    = ch_lru_wen[i];
        way_0_addr = ch_way0_addr[i*AW +: AW];
        way_1_addr = ch_way1_addr[i*AW +: AW];
        lru_addr   = ch_lru_addr[i*AW +: AW];
        way_0_din  = ch_way0_din[i*SW +: SW];
        way_1_din  = ch_way1_din[i*SW +: SW];
        lru_din    = ch_lru_din[i];
      end
    end
  end

  assign ch_way0_dout = way_0_dout;
  assign ch_way1_dout = way_1_dout;
  assign ch_lru_dout  = lru_dout;

`ifdef ICM_SRAM_ARB_PERF_EN
  logic [2:0][31:0] perf_grant_q, perf_wait_q;

  for (genvar g = 0; g < ARB_CH_NUM; g++) begin : g_perf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        perf_grant_q[g] <= '0;
        perf_wait_q[g]  <= '0;
      end else begin
        if (state_q == IDLE_s && pick[g]) perf_grant_q[g] <= perf_grant_q[g] + 32'd1;
        if (req[g] && !gnt_q[g])          perf_wait_q[g]  <= perf_wait_q[g] + 32'd1;
      end
    end
  end

  assign perf_grant_cnt = perf_grant_q;
  assign perf_wait_cnt  = perf_wait_q;
`endif

endmodule

// File: tb/tb_icm_buffer_sram_arbiter.sv
// Self-checking bench for icm_buffer_sram_arbiter: owner-level model with a
// per-cycle compare, plus directed literal checks.
module tb_icm_buffer_sram_arbiter;

  localparam int AW = 10;
  localparam int SW = 267;
  localparam int MH = 16;

  logic           clk, rst_n;
  logic [2:0]     req, gnt;
  logic [2:0]     ch_way0_wen, ch_way1_wen, ch_lru_wen, ch_lru_din;
  logic [3*AW-1:0] ch_way0_addr, ch_way1_addr, ch_lru_addr;
  logic [3*SW-1:0] ch_way0_din, ch_way1_din;
  logic           way_0_wen, way_1_wen, lru_wen, lru_din;
  logic [AW-1:0]  way_0_addr, way_1_addr, lru_addr;
  logic [SW-1:0]  way_0_din, way_1_din, way_0_dout, way_1_dout;
  logic [SW-1:0]  ch_way0_dout, ch_way1_dout;
  logic           lru_dout, ch_lru_dout, hold_err;
`ifdef ICM_SRAM_ARB_PERF_EN
  logic [3*32-1:0] perf_grant_cnt, perf_wait_cnt;
`endif

  icm_buffer_sram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .ch_way0_wen(ch_way0_wen), .ch_way1_wen(ch_way1_wen), .ch_lru_wen(ch_lru_wen),
    .ch_way0_addr(ch_way0_addr), .ch_way1_addr(ch_way1_addr), .ch_lru_addr(ch_lru_addr),
    .ch_way0_din(ch_way0_din), .ch_way1_din(ch_way1_din), .ch_lru_din(ch_lru_din),
    .way_0_wen(way_0_wen), .way_1_wen(way_1_wen), .lru_wen(lru_wen),
    .way_0_addr(way_0_addr), .way_1_addr(way_1_addr), .lru_addr(lru_addr),
    .way_0_din(way_0_din), .way_1_din(way_1_din), .lru_din(lru_din),
    .way_0_dout(way_0_dout), .way_1_dout(way_1_dout), .lru_dout(lru_dout),
    .ch_way0_dout(ch_way0_dout), .ch_way1_dout(ch_way1_dout), .ch_lru_dout(ch_lru_dout),
    .hold_err(hold_err)
`ifdef ICM_SRAM_ARB_PERF_EN
    , .perf_grant_cnt(perf_grant_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner is a channel number (-1 = nobody), ptr is the next preferred channel.
  int m_owner, m_ptr, m_hold;
  bit m_err;
  int unsigned m_gcnt[3], m_wcnt[3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1; m_ptr <= 0; m_hold <= 0; m_err <= 1'b0;
      for (int i = 0; i < 3; i++) begin m_gcnt[i] <= 0; m_wcnt[i] <= 0; end
    end else begin
      int o, p, h;
      bit e;
      o = m_owner; p = m_ptr; h = m_hold; e = m_err;
      for (int i = 0; i < 3; i++) if (req[i] && o != i) m_wcnt[i] <= m_wcnt[i] + 1;
      if (o < 0) begin
        for (int k = 0; k < 3; k++)
          if (o < 0 && req[(p + k) % 3]) begin
            o = (p + k) % 3; h = 0;
            m_gcnt[o] <= m_gcnt[o] + 1;
          end
      end else begin
        for (int i = 0; i < 3; i++) if (i != o && req[i] && h == MH) e = 1'b1;
        if (req[o]) h = (h < MH) ? h + 1 : MH;
        else begin p = (o + 1) % 3; o = -1; end
      end
      m_owner <= o; m_ptr <= p; m_hold <= h; m_err <= e;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [2:0] eg;
      logic [AW+SW:0] e0, e1;
      logic [AW+1:0] el;
      int o;
      o = m_owner;
      eg = '0; e0 = '0; e1 = '0; el = '0;
      if (o >= 0) begin
        eg[o] = 1'b1;
        e0 = {ch_way0_wen[o], ch_way0_addr[o*AW +: AW], ch_way0_din[o*SW +: SW]};
        e1 = {ch_way1_wen[o], ch_way1_addr[o*AW +: AW], ch_way1_din[o*SW +: SW]};
        el = {ch_lru_wen[o], ch_lru_addr[o*AW +: AW], ch_lru_din[o]};
      end
      check("gnt", gnt, eg);
      check("hold_err", hold_err, m_err);
      check("way0_bus", {way_0_wen, way_0_addr, way_0_din}, e0);
      check("way1_bus", {way_1_wen, way_1_addr, way_1_din}, e1);
      check("lru_bus", {lru_wen, lru_addr, lru_din}, el);
      check("dout0", ch_way0_dout, way_0_dout);
      check("dout1_lru", {ch_way1_dout, ch_lru_dout}, {way_1_dout, lru_dout});
`ifdef ICM_SRAM_ARB_PERF_EN
      check("perf_grant", perf_grant_cnt, {m_gcnt[2], m_gcnt[1], m_gcnt[0]});
      check("perf_wait", perf_wait_cnt, {m_wcnt[2], m_wcnt[1], m_wcnt[0]});
`endif
    end
  end

  function automatic logic [SW-1:0] rnd_w();
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r = {r[SW-33:0], 32'($urandom())};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int own, wt;
    int exp_order[4];
    exp_order = '{0, 1, 2, 0};
    rst_n = 1'b0; req = '0;
    ch_way0_wen = 3'b111; ch_way1_wen = 3'b111; ch_lru_wen = 3'b111; ch_lru_din = 3'b111;
    ch_way0_addr = {10'h3AA, 10'h2CC, 10'h155};
    ch_way1_addr = {10'h0F0, 10'h00F, 10'h111};
    ch_lru_addr  = {10'h222, 10'h333, 10'h044};
    ch_way0_din = {rnd_w(), rnd_w(), rnd_w()};
    ch_way1_din = {rnd_w(), rnd_w(), rnd_w()};
    way_0_dout = rnd_w(); way_1_dout = rnd_w(); lru_dout = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Reset state: channels drive writes but nothing is granted.
    @(negedge clk);
    check("rst_gnt", gnt, 3'b000);
    check("rst_err", hold_err, 1'b0);
    check("rst_wen", {way_0_wen, way_1_wen, lru_wen}, 3'b000);
    check("rst_addr", {way_0_addr, way_1_addr, lru_addr}, 30'h0);

    // Single request: one-cycle grant latency, owner's address muxed through.
    tick(); req = 3'b001;
    @(negedge clk); check("t1_latency", gnt, 3'b000);
    tick();
    @(negedge clk);
    check("t1_gnt", gnt, 3'b001);
    check("t1_addr", way_0_addr, 10'h155);
    check("t1_wen", way_0_wen, 1'b1);
    tick(); req = 3'b000;
    tick();
    @(negedge clk); check("t1_release", gnt, 3'b000);

    // All three from reset: ch0, ch1, ch2, ch0 with one idle cycle between.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      wt = 0;
      @(negedge clk);
      while (gnt == 3'b000 && wt < 10) begin @(negedge clk); wt++; end
      if (gnt == 3'b000) begin
        check("t2_timeout", gnt, 3'b111);
        break;
      end
      own = (gnt == 3'b001) ? 0 : (gnt == 3'b010) ? 1 : 2;
      check("t2_order", own, exp_order[g]);
      @(negedge clk); @(negedge clk);
      @(posedge clk); #1 req[own] = 1'b0;
      @(negedge clk); check("t2_held4", gnt, 3'b001 << own);
      @(negedge clk); check("t2_idle", gnt, 3'b000);
      @(posedge clk); #1;
      if (g < 3) req[own] = 1'b1; else req = 3'b000;
    end
    tick(); tick();

    // Owner ch1 writes LRU while ch0 also asserts write enables.
    ch_lru_wen = 3'b011; ch_lru_addr = {10'h000, 10'h003, 10'h007}; ch_lru_din = 3'b010;
    ch_way0_wen = 3'b001; ch_way1_wen = 3'b001;
    req = 3'b010;
    tick();
    @(negedge clk);
    check("t3_gnt", gnt, 3'b010);
    check("t3_lru", {lru_wen, lru_addr, lru_din}, {1'b1, 10'h003, 1'b1});
    check("t3_way_wen", {way_0_wen, way_1_wen}, 2'b00);
    tick(); req = 3'b000;
    tick(); tick();

    // ch2 holds 20 cycles with ch0 waiting: sticky hold_err, no revocation.
    req = 3'b100;
    tick();
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check("t4_gnt_held", gnt, 3'b100);
      if (c == 1) req = 3'b101;
      if (c == 17) check("t4_err_pre", hold_err, 1'b0);
      if (c == 18) check("t4_err_set", hold_err, 1'b1);
      if (c == 20) req = 3'b001;
    end
    @(negedge clk); check("t4_idle", gnt, 3'b000);
    @(negedge clk);
    check("t4_next", gnt, 3'b001);
    check("t4_sticky", hold_err, 1'b1);
    tick(); req = 3'b000;
    tick(); tick();

    // Async reset mid-grant.
    ch_way0_wen = 3'b010; ch_way1_wen = 3'b010; ch_lru_wen = 3'b010;
    req = 3'b010;
    tick();
    @(negedge clk);
    check("t5_pre_gnt", gnt, 3'b010);
    check("t5_pre_wen", way_0_wen, 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("t5_rst_gnt", gnt, 3'b000);
    check("t5_rst_wen", {way_0_wen, way_1_wen, lru_wen}, 3'b000);
    check("t5_rst_err", hold_err, 1'b0);
    req = 3'b111;
    tick(); rst_n = 1'b1;
    @(negedge clk); check("t5_post_idle", gnt, 3'b000);
    @(negedge clk); check("t5_post_gnt", gnt, 3'b001);
    tick(); req = 3'b000;
    tick(); tick();

    // Random traffic, checked by the model every cycle.
    for (int n = 0; n < 300; n++) begin
      tick();
      req = 3'($urandom_range(0, 7));
      if (n % 4 != 0) req = req | gnt;
      ch_way0_wen = 3'($urandom()); ch_way1_wen = 3'($urandom());
      ch_lru_wen = 3'($urandom()); ch_lru_din = 3'($urandom());
      ch_way0_addr = 30'($urandom()); ch_way1_addr = 30'($urandom()); ch_lru_addr = 30'($urandom());
      ch_way0_din = {rnd_w(), rnd_w(), rnd_w()};
      ch_way1_din = {rnd_w(), rnd_w(), rnd_w()};
      way_0_dout = rnd_w(); way_1_dout = rnd_w(); lru_dout = 1'($urandom());
    end
    tick(); req = 3'b000;
    tick(); tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icm_buffer_sram_arbiter.md
Name: icm_buffer_sram_arbiter

Overview:
- Shares one ICM cache SRAM set (way_0, way_1, LRU) between three threads: Get (ch0), Set/fill (ch1), Invalidate (ch2).
- Each thread drives a full SRAM command bundle and holds a request for the whole multi-cycle operation (read, compare, LRU update). The arbiter grants one owner at a time, round-robin.
- The owner's bundle is muxed onto the SRAM, and dout is broadcast to all threads.
- Sits between the ICMBuffer thread modules and the SRAM instances, one instance per ICM cache type.

Parameters:
- CACHE_ENTRY_WIDTH, 256, data bits per way entry
- CACHE_TAG_WIDTH, 10, tag bits per way entry
- CACHE_SET_NUM_LOG, 10, SRAM address width
- SRAM_WIDTH, CACHE_ENTRY_WIDTH+CACHE_TAG_WIDTH+1, way word width ({valid, tag, data})
- MAX_HOLD, 16, grant-hold cycles after which a contended owner is flagged
- MAX_HOLD_LOG, 5, width of the hold counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  3  per-channel request; must stay high for the whole operation
- gnt  out  3  one-hot registered grant
- ch_way0_wen / ch_way1_wen / ch_lru_wen  in  3 each  per-channel write enables
- ch_way0_addr / ch_way1_addr / ch_lru_addr  in  3*CACHE_SET_NUM_LOG each  packed; channel i at [i*W +: W]
- ch_way0_din / ch_way1_din  in  3*SRAM_WIDTH each  packed write data
- ch_lru_din  in  3  per-channel LRU write bit
- way_0_wen, way_1_wen, lru_wen  out  1 each  SRAM write enables
- way_0_addr, way_1_addr, lru_addr  out  CACHE_SET_NUM_LOG each
- way_0_din, way_1_din  out  SRAM_WIDTH;  lru_din  out  1
- way_0_dout, way_1_dout  in  SRAM_WIDTH;  lru_dout  in  1
- ch_way0_dout, ch_way1_dout  out  SRAM_WIDTH  broadcast of SRAM dout to all channels
- ch_lru_dout  out  1  broadcast of lru_dout
- hold_err  out  1  sticky: owner exceeded MAX_HOLD while another channel was waiting

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM → IDLE_s, gnt=0, rr_ptr=0, hold_cnt=0, hold_err=0.
  - All SRAM outputs are 0 (no write, addr 0).
- FSM states: IDLE_s, GRANT_s.
  - IDLE_s: if any req is high, choose the first requester at or after rr_ptr (mod 3). Register gnt one-hot, go to GRANT_s. Grant latency is one cycle from the req rising edge.
  - GRANT_s: stay while req[owner] is high. When req[owner] is low, clear gnt and go to IDLE_s. Set rr_ptr = owner+1 (wraps 2→0).
  - Minimum one IDLE_s cycle between grants. No back-to-back ownership change in the same cycle.
- SRAM mux:
  - In GRANT_s, outputs are combinationally equal to the owner's bundle. Reads are issued in the same cycle the owner drives them.
  - In IDLE_s, or with no grant, all wen=0, addr=0, din=0.
  - A non-owner's wen is ignored; that channel must not act on dout.
- dout is passed through unregistered to all channels. The SRAM read latency seen by the owner is unchanged.
- Request discipline: a request is deasserted only after the channel's response handshake completes. A req drop while not granted just withdraws the request; it is legal and has no effect.
- hold_cnt:
  - Resets to 0 on each new grant.
  - Increments each cycle in GRANT_s, saturating at MAX_HOLD.
  - If hold_cnt==MAX_HOLD and any other req is high, set hold_err (sticky until reset).
  - The grant is never forcibly revoked.
- Simultaneous events:
  - All three requests in IDLE_s: the rr_ptr channel wins.
  - Owner drop plus new requests in the same cycle: go to IDLE_s, arbitrate on the next cycle with the updated rr_ptr.
- Reset mid-grant: gnt drops immediately (asynchronous). The thread's own reset restarts its FSM, and no partial write is issued after reset.

Optional Feature:
- Macro: ICM_SRAM_ARB_PERF_EN.
- When defined, adds the following, cleared at reset:
  - Outputs perf_grant_cnt (3x32, packed): grants per channel.
  - Outputs perf_wait_cnt (3x32, packed): cycles each channel has req high without gnt.
  - Both counters wrap at 2^32.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header (protocol_engine_def.vh): channel index constants ARB_CH_GET=0, ARB_CH_SET=1, ARB_CH_DEL=2, plus ARB_CH_NUM=3.
- Sub-module icm_rr_pick3: combinational round-robin picker (req[2:0], rr_ptr → one-hot). It is separately testable. The FSM, mux and counters stay in the top module.

Test Plan:
- Single req[0] raised at cycle 5 → gnt=3'b001 at cycle 6; way_0_addr follows ch_way0_addr[9:0]=10'h155 in cycle 6.
- All three req high from reset, each released after 4 grant cycles → grant order ch0, ch1, ch2, ch0, with one idle cycle between grants.
- ch1 owner drives ch_lru_wen=1, addr 10'h3; ch0 simultaneously drives wen=1 → only the ch1 write reaches lru_wen/lru_addr; way writes stay 0.
- ch2 holds grant for 20 cycles while req[0] waits → hold_err rises at hold_cnt==16 and stays 1 after release; gnt is not revoked early.
- rst_n pulsed low mid-grant at cycle 10 → gnt=0 and all SRAM wen=0 in the same cycle; after release, the first grant goes to ch0 (rr_ptr=0).
- With ICM_SRAM_ARB_PERF_EN: req[1] waits 3 cycles then is granted → perf_wait_cnt[ch1]=3, perf_grant_cnt[ch1]=1.
